// File: rtl/cereal_rx.sv
// 8N1 serial receiver: two-flop synchronizer, midpoint-sampling frame FSM and
// a first-word-fall-through byte FIFO with sticky overflow.
module cereal_rx #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int FIFO_AW      = 4
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic               serialIn,
  input  logic               rd_en,
  output logic [7:0]         rd_data,
  output logic               empty,
  output logic               full,
  output logic [FIFO_AW:0]   count,
  output logic               busy,
  output logic               frame_err,
  output logic               overflow
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CNT_W-1:0]   HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]   BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CNT1      = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   FULL_CNT  = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               sync_q, rx_s_q;
  logic               push, ferr_d, frame_err_q;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               overflow_q;
  logic               do_push, do_pop;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      sync_q <= serialIn;
      rx_s_q <= sync_q;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= ferr_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          // Line back high at mid start bit means a glitch, not a frame.
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A pop frees the slot a simultaneous push needs, so push+pop works even when full.
  assign do_pop  = rd_en && (count_q != '0);
  assign do_push = push && ((count_q != FULL_CNT) || do_pop);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT1;
        2'b01:   count_q <= count_q - CNT1;
        default: count_q <= count_q;
      endcase
      if (push && !do_push) overflow_q <= 1'b1;
    end
  end

  // NOTE: storage is not reset; pointers and count define which entries are valid.
  always_ff @(posedge sysclk) begin
    if (do_push) mem[wr_ptr_q] <= shift_q;
  end

  assign rd_data   = mem[rd_ptr_q];
  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign count     = count_q;
  assign busy      = (state_q != S_IDLE);
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_cereal_rx.sv
// Directed bench for cereal_rx at 16 clocks per bit with a 16-entry FIFO.
module tb_cereal_rx;

  localparam int CPB = 16;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       serialIn;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty, full, busy, frame_err, overflow;
  logic [4:0] count;

  int tests = 0;
  int fails = 0;
  int ferr_cnt = 0;
  logic busy_seen = 1'b0;

  cereal_rx #(.CLKS_PER_BIT(CPB), .FIFO_AW(4)) dut (
    .sysclk(sysclk), .reset(reset), .serialIn(serialIn), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .busy(busy), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) begin
    if (frame_err === 1'b1) ferr_cnt++;
    if (busy === 1'b1) busy_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame starting at a falling clock edge; the line is left at stop_bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    serialIn = 1'b0;
    repeat (CPB) @(negedge sysclk);
    for (int i = 0; i < 8; i++) begin
      serialIn = b[i];
      repeat (CPB) @(negedge sysclk);
    end
    serialIn = stop_bit;
    repeat (CPB) @(negedge sysclk);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, {24'd0, rd_data}, {24'd0, exp});
    rd_en = 1'b1;
    @(negedge sysclk);
    rd_en = 1'b0;
  endtask

  initial begin
    int cycles;
    int ferr0;
    reset = 1'b1;
    serialIn = 1'b1;
    rd_en = 1'b0;
    repeat (4) @(negedge sysclk);
    reset = 1'b0;
    @(negedge sysclk);

    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovf", overflow, 0);

    // Single byte with latency measurement from the start-bit falling edge.
    cycles = 0;
    fork
      send_frame(8'h55, 1'b1);
      begin
        while (empty === 1'b1 && cycles < 400) begin
          @(negedge sysclk);
          cycles++;
        end
      end
    join
    check("latency", (cycles >= 154 && cycles <= 156) ? 155 : cycles, 155);
    check("t1_data", rd_data, 8'h55);
    check("t1_count", count, 1);
    pop_check("t1_pop", 8'h55);
    check("t1_empty", empty, 1);
    check("t1_count0", count, 0);
    check("t1_noferr", ferr_cnt, 0);

    // Start-bit glitch.
    repeat (5) @(negedge sysclk);
    busy_seen = 1'b0;
    serialIn = 1'b0;
    repeat (4) @(negedge sysclk);
    serialIn = 1'b1;
    repeat (30) @(negedge sysclk);
    check("t2_busy_seen", busy_seen, 1);
    check("t2_busy", busy, 0);
    check("t2_empty", empty, 1);
    check("t2_noferr", ferr_cnt, 0);

    // Framing error then line held low.
    ferr0 = ferr_cnt;
    send_frame(8'hA3, 1'b0);
    repeat (40) @(negedge sysclk);
    check("t3_ferr_once", ferr_cnt - ferr0, 1);
    check("t3_busy_break", busy, 1);
    check("t3_empty", empty, 1);
    serialIn = 1'b1;
    repeat (6) @(negedge sysclk);
    check("t3_busy_rel", busy, 0);
    send_frame(8'h3C, 1'b1);
    check("t3_next_count", count, 1);
    pop_check("t3_next", 8'h3C);
    check("t3_ferr_total", ferr_cnt - ferr0, 1);

    // Back-to-back frames.
    repeat (5) @(negedge sysclk);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h81, 1'b1);
    check("t4_count", count, 3);
    pop_check("t4_b0", 8'h00);
    pop_check("t4_b1", 8'hFF);
    pop_check("t4_b2", 8'h81);
    check("t4_empty", empty, 1);

    // Fill, overflow, drain, then streaming across pointer wrap.
    for (int i = 1; i <= 16; i++) send_frame(8'(i), 1'b1);
    check("t5_full", full, 1);
    check("t5_count16", count, 16);
    check("t5_ovf0", overflow, 0);
    send_frame(8'h11, 1'b1);
    check("t5_ovf1", overflow, 1);
    check("t5_full17", full, 1);
    check("t5_count17", count, 16);
    for (int i = 1; i <= 16; i++) pop_check("t5_drain", 8'(i));
    check("t5_empty", empty, 1);
    for (int k = 0; k < 20; k++) begin
      send_frame(8'(8'h20 + k), 1'b1);
      check("t5_wrap_count", count, 1);
      pop_check("t5_wrap", 8'(8'h20 + k));
    end
    check("t5_ovf_kept", overflow, 1);
    check("t5_empty2", empty, 1);

    // Reset during data bit 4 with two bytes queued.
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check("t6_pre_count", count, 2);
    serialIn = 1'b0;
    repeat (CPB) @(negedge sysclk);
    for (int i = 0; i < 4; i++) begin
      serialIn = (i == 3) ? 1'b0 : 1'b1;
      repeat (CPB) @(negedge sysclk);
    end
    serialIn = 1'b1;
    repeat (CPB / 2) @(negedge sysclk);
    check("t6_pre_busy", busy, 1);
    reset = 1'b1;
    @(negedge sysclk);
    reset = 1'b0;
    check("t6_empty", empty, 1);
    check("t6_count", count, 0);
    check("t6_ovf", overflow, 0);
    check("t6_busy", busy, 0);
    repeat (20) @(negedge sysclk);
    check("t6_idle", busy, 0);
    send_frame(8'h42, 1'b1);
    check("t6_next_count", count, 1);
    pop_check("t6_next", 8'h42);
    check("t6_empty2", empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
